// File: rtl/arb2x2_core.sv
`timescale 1ns/1ps
`default_nettype none
// arb2x2_core: two requesters sharing two resources; each resource runs its own
// round-robin owner FSM with grant hold and an optional contended-hold timeout.
module arb2x2_core #(
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cfg_enable,
  input  logic [HOLD_W-1:0] cfg_max_hold,
  input  logic [1:0]        req,
  input  logic [1:0]        req_dst,
  input  logic [1:0]        rel,
  output logic [1:0]        gnt,
  output logic [1:0]        gnt_dst,
  output logic [1:0]        res_busy,
  output logic [1:0]        res_owner,
  output logic [1:0]        timeout_pulse,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state    [2];
  logic [HOLD_W-1:0] hold_cnt [2];
  logic [1:0]        rr_ptr;

  logic [1:0] cand [2];   // cand[j][i]: Qi may be granted Rj this cycle
  logic [1:0] do_grant;
  logic [1:0] grant_who;
  logic [1:0] own_q;
  logic [1:0] do_release;
  logic [1:0] do_timeout;
  logic [1:0] q_granted;

  // Requester-side views are pure decodes of the registered resource state.
  assign gnt[0]     = (res_busy[0] & ~res_owner[0]) | (res_busy[1] & ~res_owner[1]);
  assign gnt[1]     = (res_busy[0] &  res_owner[0]) | (res_busy[1] &  res_owner[1]);
  assign gnt_dst[0] = res_busy[1] & ~res_owner[1];
  assign gnt_dst[1] = res_busy[1] &  res_owner[1];

  always_comb begin
    cand       = '{default: '0};
    do_grant   = '0;
    grant_who  = '0;
    own_q      = '0;
    do_release = '0;
    do_timeout = '0;
    q_granted  = '0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 2; i++) begin
        cand[j][i] = cfg_enable & req[i] & (req_dst[i] == j[0]) & ~gnt[i];
      end
      do_grant[j]  = (state[j] == IDLE) & (|cand[j]);
      grant_who[j] = (cand[j] == 2'b11) ? rr_ptr[j] : cand[j][1];
      own_q[j]     = (state[j] == OWN1);
      // A voluntary release or request drop wins over a coincident timeout.
      do_release[j] = (state[j] != IDLE) & (rel[own_q[j]] | ~req[own_q[j]]);
      do_timeout[j] = (state[j] != IDLE) & ~do_release[j]
                    & (cfg_max_hold != '0)
                    & (hold_cnt[j] == cfg_max_hold)
                    & cand[j][~own_q[j]];
    end
    for (int i = 0; i < 2; i++) begin
      q_granted[i] = (do_grant[0] & (grant_who[0] == i[0]))
                   | (do_grant[1] & (grant_who[1] == i[0]));
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int j = 0; j < 2; j++) begin
        state[j]    <= IDLE;
        hold_cnt[j] <= '0;
      end
      rr_ptr        <= '0;
      res_busy      <= '0;
      res_owner     <= '0;
      timeout_pulse <= '0;
      grant_cnt0    <= '0;
      grant_cnt1    <= '0;
    end else begin
      timeout_pulse <= '0;
      for (int j = 0; j < 2; j++) begin
        case (state[j])
          IDLE: begin
            if (do_grant[j]) begin
              state[j]     <= grant_who[j] ? OWN1 : OWN0;
              rr_ptr[j]    <= ~grant_who[j];
              hold_cnt[j]  <= HOLD_W'(1);
              res_busy[j]  <= 1'b1;
              res_owner[j] <= grant_who[j];
            end
          end
          OWN0, OWN1: begin
            if (do_release[j] | do_timeout[j]) begin
              state[j]         <= IDLE;
              hold_cnt[j]      <= '0;
              res_busy[j]      <= 1'b0;
              res_owner[j]     <= 1'b0;
              timeout_pulse[j] <= do_timeout[j];
            end else if (hold_cnt[j] != '1) begin
              hold_cnt[j] <= hold_cnt[j] + 1'b1;
            end
          end
          default: begin
            state[j]     <= IDLE;
            hold_cnt[j]  <= '0;
            res_busy[j]  <= 1'b0;
            res_owner[j] <= 1'b0;
          end
        endcase
      end
      if (q_granted[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (q_granted[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end

endmodule
`default_nettype wire
